// File: rtl/muldiv_if.sv
// Handshake and operand bundle between the execute stage and the mul/div sequencer.
interface muldiv_if #(
  parameter int DATA_W = 32
) ();
  logic              start;
  logic [2:0]        op;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              kill;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] y;

  modport master (output start, op, a, b, kill, input busy, done, y);
  modport slave  (input start, op, a, b, kill, output busy, done, y);
endinterface

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer: one shared adder, fixed 35-cycle
// latency from the start-sampling edge to the done cycle.
//
// state | meaning
// IDLE  | waiting for start; operands latched on accept
// PREP  | take magnitudes, record result sign, clear accumulator and counter
// CALC  | STEPS iterations of shift-add (mul) or restoring subtract (div)
// FIX   | apply sign, force div-by-zero results, register y
// DONE  | one-cycle done pulse, busy low
module muldiv_seq #(
  parameter int DATA_W = 32,
  parameter int STEPS  = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  muldiv_if.slave  bus
);

  localparam int CNT_W = $clog2(STEPS);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_CALC = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;
  logic [DATA_W-1:0]   md_q, md_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                neg_q, neg_d;
  logic [DATA_W-1:0]   y_q, y_d;

  // Operand sign interpretation depends on funct3.
  logic              is_div;
  logic              a_neg, b_neg;
  logic [DATA_W-1:0] abs_a, abs_b;

  assign is_div = op_q[2];
  assign a_neg  = a_q[DATA_W-1] & ((op_q == 3'd1) | (op_q == 3'd2) | (op_q == 3'd4) | (op_q == 3'd6));
  assign b_neg  = b_q[DATA_W-1] & ((op_q == 3'd1) | (op_q == 3'd4) | (op_q == 3'd6));
  assign abs_a  = a_neg ? (~a_q + 1'b1) : a_q;
  assign abs_b  = b_neg ? (~b_q + 1'b1) : b_q;

  // The single iteration adder. Divide sees the remainder shifted left with the
  // next dividend bit as a 33-bit value, so a remainder >= 2^31 still compares
  // correctly; its carry-out is the "no borrow" flag.
  logic [DATA_W:0]   add_x, add_y;
  logic [DATA_W+1:0] sum;
  logic [DATA_W-1:0] md_gated;

  assign md_gated = lo_q[0] ? md_q : {DATA_W{1'b0}};
  assign add_x    = is_div ? {hi_q, lo_q[DATA_W-1]} : {1'b0, hi_q};
  assign add_y    = is_div ? ~{1'b0, md_q} : {1'b0, md_gated};
  assign sum      = {1'b0, add_x} + {1'b0, add_y} + {{(DATA_W+1){1'b0}}, is_div};

  // Sign correction applied in FIX.
  logic [2*DATA_W-1:0] prod, prod_fix;
  logic [DATA_W-1:0]   quo_fix, rem_fix;

  assign prod     = {hi_q, lo_q};
  assign prod_fix = neg_q ? (~prod + 1'b1) : prod;
  assign quo_fix  = neg_q ? (~lo_q + 1'b1) : lo_q;
  assign rem_fix  = neg_q ? (~hi_q + 1'b1) : hi_q;

  assign bus.busy = (state_q == S_PREP) | (state_q == S_CALC) | (state_q == S_FIX);
  assign bus.done = (state_q == S_DONE);
  assign bus.y    = y_q;

  // State and datapath registers; reset clears everything asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      md_q    <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      md_q    <= md_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      y_q     <= y_d;
    end
  end

  // Next-state and datapath update; kill overrides everything outside IDLE.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    md_d    = md_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    y_d     = y_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.kill) begin
          op_d    = bus.op;
          a_d     = bus.a;
          b_d     = bus.b;
          state_d = S_PREP;
        end
      end
      S_PREP: begin
        hi_d  = '0;
        cnt_d = '0;
        if (is_div) begin
          lo_d  = abs_a;
          md_d  = abs_b;
          neg_d = (op_q == 3'd6) ? a_neg : (a_neg ^ b_neg);
        end else begin
          lo_d  = abs_b;
          md_d  = abs_a;
          neg_d = a_neg ^ b_neg;
        end
        state_d = S_CALC;
      end
      S_CALC: begin
        if (is_div) begin
          hi_d = sum[DATA_W+1] ? sum[DATA_W-1:0] : add_x[DATA_W-1:0];
          lo_d = {lo_q[DATA_W-2:0], sum[DATA_W+1]};
        end else begin
          {hi_d, lo_d} = {sum[DATA_W:0], lo_q[DATA_W-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(STEPS - 1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        case (op_q)
          3'd0:          y_d = prod_fix[DATA_W-1:0];
          3'd1, 3'd2,
          3'd3:          y_d = prod_fix[2*DATA_W-1:DATA_W];
          3'd4, 3'd5:    y_d = (b_q == '0) ? {DATA_W{1'b1}} : quo_fix;
          default:       y_d = (b_q == '0) ? a_q : rem_fix;
        endcase
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (bus.kill && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      y_d     = y_q;
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: hand-computed results, fixed latency, kill and
// asynchronous reset behaviour.
module tb_muldiv_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   dcnt;

  muldiv_if #(.DATA_W(32)) bus ();

  muldiv_seq #(.DATA_W(32), .STEPS(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Present a request for one edge, then scramble the inputs.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.op    = 3'($urandom);
    bus.a     = $urandom;
    bus.b     = $urandom;
  endtask

  // Called in cycle 1 after the accepting edge; follows the op to its done cycle.
  task automatic finish_op(input string tag, input logic [31:0] exp, input bit extra_start);
    int n;
    n = 1;
    check({tag, " busy_after_start"}, 32'(bus.busy), 32'd1);
    while (!bus.done && n < 40) begin
      if (extra_start && n == 5) begin
        bus.start = 1'b1;
        bus.op    = 3'd0;
        bus.a     = 32'd1;
        bus.b     = 32'd1;
      end
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'd35);
    check({tag, " y"}, bus.y, exp);
    check({tag, " busy_in_done"}, 32'(bus.busy), 32'd0);
    @(posedge clk);
    #1;
    check({tag, " done_width"}, 32'(bus.done), 32'd0);
  endtask

  task automatic count_dones(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) cnt++;
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.kill  = 1'b0;
    bus.op    = 3'd0;
    bus.a     = '0;
    bus.b     = '0;

    #12;
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset y", bus.y, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    issue(3'd0, 32'd7, 32'd6);                     finish_op("mul", 32'd42, 1'b0);
    issue(3'd1, 32'hFFFFFFFF, 32'd2);              finish_op("mulh", 32'hFFFFFFFF, 1'b0);
    issue(3'd3, 32'hFFFFFFFF, 32'd2);              finish_op("mulhu", 32'd1, 1'b0);
    issue(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);       finish_op("mulhsu", 32'hFFFFFFFF, 1'b0);
    issue(3'd4, 32'hFFFFFFF9, 32'd2);              finish_op("div", 32'hFFFFFFFD, 1'b0);
    issue(3'd6, 32'hFFFFFFF9, 32'd2);              finish_op("rem", 32'hFFFFFFFF, 1'b0);
    issue(3'd5, 32'd100, 32'd7);                   finish_op("divu", 32'd14, 1'b0);
    issue(3'd7, 32'd100, 32'd7);                   finish_op("remu", 32'd2, 1'b0);
    issue(3'd4, 32'h80000000, 32'hFFFFFFFF);       finish_op("div_ovf", 32'h80000000, 1'b0);
    issue(3'd6, 32'h80000000, 32'hFFFFFFFF);       finish_op("rem_ovf", 32'd0, 1'b0);
    issue(3'd5, 32'd5, 32'd0);                     finish_op("divu_by0", 32'hFFFFFFFF, 1'b0);
    issue(3'd7, 32'd5, 32'd0);                     finish_op("remu_by0", 32'd5, 1'b0);

    // Kill a multiply in its tenth cycle; y must keep the remu_by0 result.
    issue(3'd0, 32'd3, 32'd3);
    for (int i = 1; i < 10; i++) begin
      @(posedge clk);
      #1;
    end
    bus.kill = 1'b1;
    @(posedge clk);
    #1;
    bus.kill = 1'b0;
    check("kill busy", 32'(bus.busy), 32'd0);
    check("kill y", bus.y, 32'd5);
    count_dones(45, dcnt);
    check("kill no_done", 32'(dcnt), 32'd0);

    // A start during busy must not be queued.
    issue(3'd5, 32'd9, 32'd3);                     finish_op("divu_9_3", 32'd3, 1'b1);
    count_dones(45, dcnt);
    check("ignored_start no_done", 32'(dcnt), 32'd0);

    // Asynchronous reset in cycle 20 of a divide.
    issue(3'd4, 32'd100, 32'd7);
    for (int i = 1; i < 20; i++) begin
      @(posedge clk);
      #1;
    end
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst busy", 32'(bus.busy), 32'd0);
    check("async_rst done", 32'(bus.done), 32'd0);
    check("async_rst y", bus.y, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    count_dones(45, dcnt);
    check("after_rst no_done", 32'(dcnt), 32'd0);

    issue(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF);       finish_op("mulhu_max", 32'hFFFFFFFE, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative sequencer for the RV32M multiply/divide ops that the single-cycle ALU does not implement.
- Sits beside the ALU in the execute stage.
- Accepts one operation, stalls the pipeline via busy, and runs a 32-step shift-add (multiply) or restoring-subtract (divide) loop on one internal adder.
- Returns a 32-bit result with a one-cycle done pulse.

Parameters:
- DATA_W, 32, operand/result width; equals `DATA_W; only 32 is supported.
- STEPS, 32, iteration count; must equal DATA_W.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  request; sampled only when busy=0
- op  input  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- a  input  DATA_W  rs1 operand
- b  input  DATA_W  rs2 operand
- kill  input  1  pipeline flush; aborts the operation in flight
- busy  output  1  high while an operation is in progress (stall request)
- done  output  1  one-cycle pulse; y valid in this cycle
- y  output  DATA_W  result; held until the next done

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low.
- Reset values: state=IDLE, busy=0, done=0, y=0; all internal registers 0.
- States: IDLE, PREP, CALC, FIX, DONE.
- IDLE:
  - start=1 latches op, a, b; goes to PREP.
  - busy rises the cycle after start is sampled.
  - start with busy=1 is ignored (no queueing).
- PREP (1 cycle):
  - Takes absolute values of signed operands per op:
    - MULH: both signed.
    - MULHSU: a signed, b unsigned.
    - DIV/REM: both signed.
    - MUL, MULHU, DIVU, REMU: unsigned.
  - Records result sign:
    - Multiply: sign(a) XOR sign(b) over the signed operands.
    - Quotient: sign(a) XOR sign(b).
    - Remainder: sign(a).
  - Clears the 64-bit accumulator/remainder pair and the step counter.
- CALC (exactly STEPS cycles):
  - Multiply: if multiplier LSB=1, add multiplicand into the high half; shift the 64-bit pair right 1.
  - Divide: shift remainder:dividend left 1; subtract the divisor from the remainder; if no borrow, keep the difference and set the quotient LSB, else restore.
  - Counter 0..STEPS-1; leaves CALC when the counter reaches STEPS-1.
- FIX (1 cycle): applies sign negation and selects the output:
  - MUL: low 32 bits.
  - MULH/MULHSU/MULHU: high 32 bits.
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
  - Registers the selection into y.
- DONE (1 cycle): done=1, busy=0, then IDLE.
  - The start accepted in IDLE is the cycle after DONE; no back-to-back accept in DONE itself.
- Latency: done asserts exactly STEPS+3 = 35 cycles after the start-sampling edge, for every op including the special cases below.
- Divide by zero (b=0):
  - Quotient = 32'hFFFFFFFF (DIV and DIVU).
  - Remainder = a (REM and REMU).
  - Forced in FIX; the loop still runs for fixed latency.
- Signed overflow (DIV/REM, a=32'h80000000, b=32'hFFFFFFFF): quotient = 32'h80000000, remainder = 0.
- kill:
  - kill=1 in any non-IDLE state: the next state is IDLE, busy=0 next cycle, no done pulse, y unchanged.
  - kill and start together in IDLE: start is ignored.
- Reset mid-operation: rst_n low forces the reset values immediately; no done is produced afterwards.
- Inputs a, b, op may change after acceptance without affecting the result.

Test Plan:
- Reset, then MUL (op=0) a=7 b=6 -> busy=1 from the next cycle; done pulses 35 cycles after start with y=42; busy=0 in the done cycle.
- MULH a=32'hFFFFFFFF (-1), b=2 -> y=32'hFFFFFFFF. MULHU, same operands -> y=1. MULHSU a=-1, b=32'hFFFFFFFF -> y=32'hFFFFFFFF.
- DIV a=-7 (32'hFFFFFFF9), b=2 -> y=32'hFFFFFFFD (-3). REM, same operands -> y=32'hFFFFFFFF (-1). DIVU a=100, b=7 -> y=14. REMU, same operands -> y=2.
- DIVU a=5, b=0 -> y=32'hFFFFFFFF; REMU a=5, b=0 -> y=5; DIV a=32'h80000000, b=-1 -> y=32'h80000000; REM, same operands -> y=0; all at the 35-cycle latency.
- Start MUL a=3 b=3; assert kill at cycle 10 -> busy=0 next cycle, no done, y keeps its previous value. Issue DIVU 9/3 -> done at 35 cycles, y=3. A second start during busy is ignored (exactly one done).
- Drive rst_n low at cycle 20 of a DIV -> busy, done, y go 0 asynchronously, before the next clk edge. Release, issue MULHU 32'hFFFFFFFF*32'hFFFFFFFF -> y=32'hFFFFFFFE.
